rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 3, meaning the number of writeback requesters (legal 2..4).
REQ-002 The block SHALL have parameter XLEN, default 32, meaning the data width of each write.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid  input  NREQ  per-requester write request.
REQ-006 The block SHALL have port req_rd  input  5*NREQ  per-requester destination register; requester i uses bits [5i+4:5i].
REQ-007 The block SHALL have port req_data  input  XLEN*NREQ  per-requester write data; requester i uses bits [XLEN*i+XLEN-1:XLEN*i].
REQ-008 The block SHALL have port req_ready  output  NREQ  one-hot-or-zero grant; it is combinational from req_valid and the pointer.
REQ-009 The block SHALL have port rf_we  output  1  register-file write enable.
REQ-010 The block SHALL have port rf_rd  output  5  register-file write address.
REQ-011 The block SHALL have port rf_data  output  XLEN  register-file write data.
REQ-012 The block SHALL have port grant_id  output  2  index of the requester whose write is on rf_* this cycle.
REQ-013 The block SHALL have port wr_count  output  16  count of committed non-x0 writes.

Function
REQ-014 A transfer from requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-015 In any cycle, at most one bit of req_ready SHALL be 1, and req_ready[i] SHALL never be 1 while req_valid[i] is 0.
REQ-016 Arbitration SHALL be round-robin: the search for a valid requester starts at index ptr and proceeds ptr, ptr+1, ... modulo NREQ, and the first valid requester found is granted.
REQ-017 After a transfer from requester i, ptr SHALL become (i+1) mod NREQ; when no transfer occurs, ptr SHALL hold its value.
REQ-018 The latency from transfer to write SHALL be exactly one cycle: rf_we, rf_rd, rf_data and grant_id are registered from the transfer cycle and present for one cycle.
REQ-019 One transfer SHALL be accepted every cycle when any req_valid bit is set, and there SHALL be no backpressure beyond arbitration.
REQ-020 A transfer with rd=0 SHALL be accepted (ready asserted) but SHALL produce rf_we=0 in the following cycle; grant_id SHALL still be updated.
REQ-021 In a cycle with no transfer, rf_we SHALL be 0 in the next cycle, and rf_rd and rf_data SHALL hold their previous values.
REQ-022 wr_count SHALL increment by 1 on every cycle where rf_we=1, and SHALL wrap from 0xFFFF to 0x0000.
REQ-023 Fairness: a requester that holds req_valid continuously SHALL be granted within NREQ cycles.
REQ-024 Requesters SHALL hold req_rd and req_data stable while req_valid=1 and ready=0; the block SHALL sample them only in the transfer cycle.

Reset
REQ-025 While rst_n=0, the block SHALL immediately drive rf_we=0, rf_rd=0, rf_data=0, grant_id=0, wr_count=0 and ptr=0.
REQ-026 While rst_n=0, req_ready SHALL be all 0.
REQ-027 A transfer pending when reset asserts SHALL be discarded, so that no write appears after reset is released.
REQ-028 The first grant after reset release SHALL follow the pointer order starting at requester 0.

Configuration
REQ-029 With macro RF_WB_FWD_EN defined, the block SHALL add the inputs fwd_rs1 (5 bits) and fwd_rs2 (5 bits) and the outputs fwd_hit1, fwd_hit2 and fwd_data (XLEN bits).
REQ-030 With RF_WB_FWD_EN defined, fwd_hitN SHALL be combinationally 1 when rf_we=1 and rf_rd equals fwd_rsN, and fwd_data SHALL equal rf_data.
REQ-031 With RF_WB_FWD_EN defined, fwd_hit1 and fwd_hit2 SHALL be 0 while rst_n=0.
REQ-032 Without RF_WB_FWD_EN, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Single request: req 1 valid with rd=5 and data=0xDEADBEEF for one cycle -> ready[1]=1 that cycle; next cycle rf_we=1, rf_rd=5, rf_data=0xDEADBEEF, grant_id=1; wr_count=1 after that cycle.
REQ-034 Contention: all three requesters held valid for 6 cycles from reset -> grant order 0,1,2,0,1,2, and rf_we=1 on six consecutive cycles.
REQ-035 x0 write: req 0 with rd=0 and data=0x1234 -> ready[0]=1; next cycle rf_we=0 and grant_id=0; wr_count unchanged.
REQ-036 Reset mid-operation: assert rst_n=0 in the same cycle as a transfer -> rf_we=0 immediately, no write after release, and the next grant starts from requester 0.
REQ-037 Wrap: preload 0xFFFF committed writes, then issue one more write -> wr_count=0x0000.
REQ-038 Forwarding (with RF_WB_FWD_EN): write rd=7 with fwd_rs1=7 and fwd_rs2=8 -> in the write cycle fwd_hit1=1, fwd_hit2=0, fwd_data equals the write data.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter into a single register-file write port; optional forwarding via RF_WB_FWD_EN.
// Latency: one cycle from transfer to rf_* write; no backpressure beyond the one-grant-per-cycle arbitration.
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [5*NREQ-1:0]    req_rd,
  input  logic [XLEN*NREQ-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rf_we,
  output logic [4:0]           rf_rd,
  output logic [XLEN-1:0]      rf_data,
  output logic [1:0]           grant_id,
  output logic [15:0]          wr_count
`ifdef RF_WB_FWD_EN
  ,
  input  logic [4:0]           fwd_rs1,
  input  logic [4:0]           fwd_rs2,
  output logic                 fwd_hit1,
  output logic                 fwd_hit2,
  output logic [XLEN-1:0]      fwd_data
`endif
);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_t;

  logic [1:0] ptr;
  logic       gnt_any;
  logic [1:0] gnt_idx;
  wb_t        sel;

  function automatic logic [1:0] rr_idx(input logic [1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return 2'(s);
  endfunction

  // First valid requester at or after ptr wins; nothing is granted while in reset.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_any && req_valid[rr_idx(ptr, k)]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_idx(ptr, k);
      end
    end
    if (!rst_n) gnt_any = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    if (gnt_any) req_ready = {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx;
  end

  always_comb begin
    sel.rd   = req_rd[5*int'(gnt_idx) +: 5];
    sel.data = req_data[XLEN*int'(gnt_idx) +: XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= 2'd0;
      rf_we    <= 1'b0;
      rf_rd    <= 5'd0;
      rf_data  <= '0;
      grant_id <= 2'd0;
    end else begin
      // x0 transfers are consumed and still move grant_id, but never write.
      rf_we <= gnt_any && (sel.rd != 5'd0);
      if (gnt_any) begin
        ptr      <= rr_idx(gnt_idx, 1);
        rf_rd    <= sel.rd;
        rf_data  <= sel.data;
        grant_id <= gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= 16'd0;
    end else if (rf_we) begin
      wr_count <= wr_count + 16'd1;
    end
  end

`ifdef RF_WB_FWD_EN
  assign fwd_hit1 = rst_n && rf_we && (rf_rd == fwd_rs1);
  assign fwd_hit2 = rst_n && rf_we && (rf_rd == fwd_rs2);
  assign fwd_data = rf_data;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: random and directed traffic against a round-robin reference model with a write scoreboard.
module tb_rf_wb_arbiter;
  localparam int NREQ = 3;
  localparam int XLEN = 32;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [5*NREQ-1:0]    req_rd = '0;
  logic [XLEN*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 rf_we;
  logic [4:0]           rf_rd;
  logic [XLEN-1:0]      rf_data;
  logic [1:0]           grant_id;
  logic [15:0]          wr_count;
`ifdef RF_WB_FWD_EN
  logic [4:0]           fwd_rs1 = 5'd7;
  logic [4:0]           fwd_rs2 = 5'd8;
  logic                 fwd_hit1, fwd_hit2;
  logic [XLEN-1:0]      fwd_data;
`endif

  rf_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data), .grant_id(grant_id), .wr_count(wr_count)
`ifdef RF_WB_FWD_EN
    , .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    int          gid;
    logic [15:0] cnt;
  } rec_t;

  rec_t        q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          m_ptr = 0;
  logic [15:0] m_cnt = 16'd0;
  logic        last_known = 1'b1;
  logic [4:0]  last_rd = 5'd0;
  logic [31:0] last_dat = 32'd0;

  logic        s_v   [NREQ];
  logic [4:0]  s_rd  [NREQ];
  logic [31:0] s_dat [NREQ];
  logic        pend  [NREQ];
  int          last_g;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NREQ; i++) begin
      s_v[i] = 1'b0; s_rd[i] = 5'd0; s_dat[i] = 32'd0;
    end
  endtask

  // Drive one cycle of stimulus, predict the grant and queue the expected write.
  task automatic apply();
    int g;
    logic [NREQ-1:0] exp_ready;
    rec_t r;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = s_v[i];
      req_rd[5*i +: 5]      = s_rd[i];
      req_data[XLEN*i +: XLEN] = s_dat[i];
    end
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (g < 0 && s_v[j]) g = j;
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    #1;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    if (g >= 0) begin
      r.tag = cyc + 1; r.we = (s_rd[g] != 5'd0); r.rd = s_rd[g]; r.data = s_dat[g];
      r.gid = g; r.cnt = m_cnt;
      q.push_back(r);
      if (r.we) m_cnt = m_cnt + 16'd1;
      m_ptr = (g + 1) % NREQ;
    end
    last_g = g;
  endtask

  task automatic idle(input int n);
    clear_stim();
    for (int i = 0; i < n; i++) apply();
  endtask

  // Monitor: pops an expected write when its cycle comes up, otherwise demands a quiet port.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      #2;
      while (q.size() > 0 && q[0].tag < cyc) begin
        r = q.pop_front();
        check("missed_write", 64'(cyc), 64'(r.tag));
      end
      if (q.size() > 0 && q[0].tag == cyc) begin
        r = q.pop_front();
        check("rf_we", 64'(rf_we), 64'(r.we));
        check("grant_id", 64'(grant_id), 64'(r.gid));
        if (r.we) begin
          check("rf_rd", 64'(rf_rd), 64'(r.rd));
          check("rf_data", 64'(rf_data), 64'(r.data));
          check("wr_count", 64'(wr_count), 64'(r.cnt));
          last_known = 1'b1; last_rd = r.rd; last_dat = r.data;
        end else begin
          check("wr_count_x0", 64'(wr_count), 64'(r.cnt));
          last_known = 1'b0;
        end
`ifdef RF_WB_FWD_EN
        check("fwd_hit1", 64'(fwd_hit1), 64'(r.we && r.rd == fwd_rs1));
        check("fwd_hit2", 64'(fwd_hit2), 64'(r.we && r.rd == fwd_rs2));
        if (r.we) check("fwd_data", 64'(fwd_data), 64'(r.data));
`endif
      end else begin
        check("rf_we_idle", 64'(rf_we), 64'(0));
        if (last_known) begin
          check("rf_rd_hold", 64'(rf_rd), 64'(last_rd));
          check("rf_data_hold", 64'(rf_data), 64'(last_dat));
        end
`ifdef RF_WB_FWD_EN
        check("fwd_hit1_idle", 64'(fwd_hit1), 64'(0));
`endif
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_state();
    check("rst_rf_we", 64'(rf_we), 64'(0));
    check("rst_rf_rd", 64'(rf_rd), 64'(0));
    check("rst_rf_data", 64'(rf_data), 64'(0));
    check("rst_grant_id", 64'(grant_id), 64'(0));
    check("rst_wr_count", 64'(wr_count), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
`ifdef RF_WB_FWD_EN
    check("rst_fwd_hit1", 64'(fwd_hit1), 64'(0));
    check("rst_fwd_hit2", 64'(fwd_hit2), 64'(0));
`endif
  endtask

  // Reset lands in the same cycle as a pending transfer; that transfer must vanish.
  task automatic mid_reset();
    for (int i = 0; i < NREQ; i++) begin
      s_v[i] = 1'b1; s_rd[i] = 5'd9 + 5'(i); s_dat[i] = 32'hA000_0000 + i;
    end
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = 1'b1; req_rd[5*i +: 5] = s_rd[i]; req_data[XLEN*i +: XLEN] = s_dat[i];
    end
    #1;
    rst_n = 1'b0;
    q.delete();
    m_ptr = 0; m_cnt = 16'd0;
    last_known = 1'b1; last_rd = 5'd0; last_dat = 32'd0;
    #1;
    check_reset_state();
    repeat (2) @(negedge clk);
    #1;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = '0;
  endtask

  initial begin
    clear_stim();
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    req_valid = '1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = '0;

    // All requesters contend from reset: expect 0,1,2,0,1,2.
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        s_v[i] = 1'b1; s_rd[i] = 5'(i + 1); s_dat[i] = 32'h1000 * (c + 1) + i;
      end
      apply();
    end
    idle(2);

    clear_stim();
    s_v[1] = 1'b1; s_rd[1] = 5'd5; s_dat[1] = 32'hDEADBEEF;
    apply();
    idle(2);
    check("wr_count_after_single", 64'(wr_count), 64'(7));

    clear_stim();
    s_v[0] = 1'b1; s_rd[0] = 5'd0; s_dat[0] = 32'h1234;
    apply();
    idle(2);
    check("wr_count_after_x0", 64'(wr_count), 64'(7));

`ifdef RF_WB_FWD_EN
    clear_stim();
    s_v[2] = 1'b1; s_rd[2] = 5'd7; s_dat[2] = 32'hCAFE0007;
    apply();
    idle(2);
`endif

    // Random traffic; a requester left waiting keeps its rd/data stable.
    for (int it = 0; it < 400; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i]) begin
          s_v[i]   = ($urandom_range(0, 2) != 0);
          s_rd[i]  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(6, 9)) : 5'($urandom_range(0, 31));
          s_dat[i] = $urandom;
        end
      end
      if ($urandom_range(0, 9) == 0) clear_stim();
      apply();
      for (int i = 0; i < NREQ; i++) pend[i] = s_v[i] && (i != last_g);
    end
    idle(2);

    mid_reset();
    for (int i = 0; i < NREQ; i++) begin
      s_v[i] = 1'b1; s_rd[i] = 5'd20 + 5'(i); s_dat[i] = 32'hB000_0000 + i;
    end
    apply();
    check("first_grant_after_reset", 64'(last_g), 64'(0));
    idle(2);

    // Stream writes up to 0xFFFF commits, then one more must wrap the counter.
    while (m_cnt != 16'hFFFF) begin
      for (int i = 0; i < NREQ; i++) begin
        s_v[i] = 1'b1; s_rd[i] = 5'($urandom_range(1, 31)); s_dat[i] = $urandom;
      end
      apply();
    end
    idle(2);
    check("wr_count_preload", 64'(wr_count), 64'(16'hFFFF));
    clear_stim();
    s_v[2] = 1'b1; s_rd[2] = 5'd3; s_dat[2] = 32'h5555AAAA;
    apply();
    idle(2);
    check("wr_count_wrap", 64'(wr_count), 64'(16'h0000));

    idle(2);
    check("scoreboard_drained", 64'(q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
